// File: rtl/regfile_clr_gen2.sv
// Integer register file for the single-cycle RISC-V datapath.
// It has two combinational read ports, one synchronous write port and one
// debug read port. A clear sequencer zeroes the array one entry per cycle
// after reset or on request. Because the array needs no reset network, it
// stays RAM-inferable. An optional bypass forwards a same-cycle write to a
// matching read port.
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | zeroing array[clrPtr] each cycle; writes ignored, reads forced 0
// RUN   | array valid, writes accepted, ready=1
module regfile_clr_gen2 #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            RegWrite,
   input  logic [AW-1:0]   writeReg,
   input  logic [XLEN-1:0] writeData,
   input  logic [AW-1:0]   readReg1,
   input  logic [AW-1:0]   readReg2,
   output logic [XLEN-1:0] readData1,
   output logic [XLEN-1:0] readData2,
   input  logic [AW-1:0]   dbg_addr,
   output logic [XLEN-1:0] dbg_data,
   input  logic            clr_req,
   output logic            ready,
   output logic [AW-1:0]   clr_ptr_o
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t          state;
   state_t          stateNext;
   logic [AW-1:0]   clrPtr;
   logic [AW-1:0]   clrPtrNext;

   // The clear sequencer and the write port share one array write port.
   logic            memWe;
   logic [AW-1:0]   memAddr;
   logic [XLEN-1:0] memData;

   logic [XLEN-1:0] regs [NREGS];

   // State register and clear pointer; reset restarts the full clear sequence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= CLEAR;
         clrPtr <= '0;
      end else begin
         state  <= stateNext;
         clrPtr <= clrPtrNext;
      end
   end

   // Next-state logic and write-port steering. A clear request wins over a write.
   always_comb begin
      stateNext  = state;
      clrPtrNext = clrPtr;
      memWe      = 1'b0;
      memAddr    = writeReg;
      memData    = writeData;
      case (state)
         CLEAR: begin
            memWe   = 1'b1;
            memAddr = clrPtr;
            memData = '0;
            if (clrPtr == LAST_IDX) begin
               stateNext  = RUN;
               clrPtrNext = '0;
            end else begin
               clrPtrNext = clrPtr + 1'b1;
            end
         end
         RUN: begin
            if (clr_req) begin
               stateNext  = CLEAR;
               clrPtrNext = '0;
            end else if (RegWrite && (writeReg != '0)) begin
               memWe = 1'b1;
            end
         end
         default: begin
            stateNext  = CLEAR;
            clrPtrNext = '0;
         end
      endcase
   end

   // Array storage: there is no reset here, so the clear sequencer zeroes it.
   always_ff @(posedge clk) begin
      if (memWe) begin
         regs[memAddr] <= memData;
      end
   end

   // Read port 1: x0 reads zero, then the optional bypass, then the array.
   always_comb begin
      readData1 = '0;
      if ((state == RUN) && (readReg1 != '0)) begin
         if ((BYPASS != 0) && RegWrite && !clr_req && (writeReg == readReg1)) begin
            readData1 = writeData;
         end else begin
            readData1 = regs[readReg1];
         end
      end
   end

   // Read port 2: same rules as port 1.
   always_comb begin
      readData2 = '0;
      if ((state == RUN) && (readReg2 != '0)) begin
         if ((BYPASS != 0) && RegWrite && !clr_req && (writeReg == readReg2)) begin
            readData2 = writeData;
         end else begin
            readData2 = regs[readReg2];
         end
      end
   end

   // Debug port: always shows the committed array contents and is never bypassed.
   always_comb begin
      dbg_data = '0;
      if ((state == RUN) && (dbg_addr != '0)) begin
         dbg_data = regs[dbg_addr];
      end
   end

   assign ready     = (state == RUN);
   assign clr_ptr_o = clrPtr;

endmodule

// File: tb/tb_regfile_clr_gen2.sv
// Testbench for regfile_clr_gen2. It drives three configurations from one
// shared stimulus stream:
//   A: 32x32, bypass on
//   B: 32x32, bypass off
//   C: 64x16, bypass on; C sees the low 4 address bits
// Each configuration is checked against its own abstract register-file model.
module tb_regfile_clr_gen2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        RegWrite, clr_req;
   logic [4:0]  writeReg, readReg1, readReg2, dbg_addr;
   logic [63:0] writeData;

   logic [31:0] rd1A, rd2A, dbgA, rd1B, rd2B, dbgB;
   logic [63:0] rd1C, rd2C, dbgC;
   logic        readyA, readyB, readyC;
   logic [4:0]  ptrA, ptrB;
   logic [3:0]  ptrC;

   always #5 clk = ~clk;

   regfile_clr_gen2 #(.XLEN(32), .NREGS(32), .BYPASS(1)) dutA (
      .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .writeReg(writeReg),
      .writeData(writeData[31:0]), .readReg1(readReg1), .readReg2(readReg2),
      .readData1(rd1A), .readData2(rd2A), .dbg_addr(dbg_addr), .dbg_data(dbgA),
      .clr_req(clr_req), .ready(readyA), .clr_ptr_o(ptrA));

   regfile_clr_gen2 #(.XLEN(32), .NREGS(32), .BYPASS(0)) dutB (
      .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .writeReg(writeReg),
      .writeData(writeData[31:0]), .readReg1(readReg1), .readReg2(readReg2),
      .readData1(rd1B), .readData2(rd2B), .dbg_addr(dbg_addr), .dbg_data(dbgB),
      .clr_req(clr_req), .ready(readyB), .clr_ptr_o(ptrB));

   regfile_clr_gen2 #(.XLEN(64), .NREGS(16), .BYPASS(1)) dutC (
      .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .writeReg(writeReg[3:0]),
      .writeData(writeData), .readReg1(readReg1[3:0]), .readReg2(readReg2[3:0]),
      .readData1(rd1C), .readData2(rd2C), .dbg_addr(dbg_addr[3:0]), .dbg_data(dbgC),
      .clr_req(clr_req), .ready(readyC), .clr_ptr_o(ptrC));

   // Reference model. For each configuration it keeps a plain array of
   // values plus a count of clear cycles still to run (0 means running).
   int          nr[3]    = '{32, 32, 16};
   bit          byp[3]   = '{1'b1, 1'b0, 1'b1};
   logic [63:0] wmask[3] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF,
                             64'hFFFF_FFFF_FFFF_FFFF};
   logic [63:0] mem [3][32];
   int          clrCnt[3];

   int passCnt  = 0;
   int totalCnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic modelReset();
      for (int k = 0; k < 3; k++) begin
         clrCnt[k] = nr[k];
         for (int i = 0; i < 32; i++) mem[k][i] = 64'd0;
      end
   endtask

   function automatic logic [63:0] expRead(input int k, input logic [4:0] a, input bit canBypass);
      int ai = int'(a) % nr[k];
      int wi = int'(writeReg) % nr[k];
      if (clrCnt[k] > 0 || ai == 0) return 64'd0;
      if (canBypass && byp[k] && RegWrite && !clr_req && wi == ai) return writeData & wmask[k];
      return mem[k][ai];
   endfunction

   task automatic modelEdge();
      if (!rst_n) begin
         modelReset();
         return;
      end
      for (int k = 0; k < 3; k++) begin
         if (clrCnt[k] > 0) begin
            clrCnt[k]--;
         end else if (clr_req) begin
            clrCnt[k] = nr[k];
            for (int i = 0; i < 32; i++) mem[k][i] = 64'd0;
         end else if (RegWrite && (int'(writeReg) % nr[k]) != 0) begin
            mem[k][int'(writeReg) % nr[k]] = writeData & wmask[k];
         end
      end
   endtask

   task automatic checkAll();
      logic [63:0] a1[3], a2[3], ad[3], ap[3];
      logic        ar[3];
      a1 = '{64'(rd1A), 64'(rd1B), rd1C};
      a2 = '{64'(rd2A), 64'(rd2B), rd2C};
      ad = '{64'(dbgA), 64'(dbgB), dbgC};
      ap = '{64'(ptrA), 64'(ptrB), 64'(ptrC)};
      ar = '{readyA, readyB, readyC};
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("dut%0d readData1", k), a1[k], expRead(k, readReg1, 1'b1));
         chk($sformatf("dut%0d readData2", k), a2[k], expRead(k, readReg2, 1'b1));
         chk($sformatf("dut%0d dbg_data", k), ad[k], expRead(k, dbg_addr, 1'b0));
         chk($sformatf("dut%0d ready", k), 64'(ar[k]), 64'(clrCnt[k] == 0));
         chk($sformatf("dut%0d clr_ptr_o", k), ap[k],
             64'((clrCnt[k] > 0) ? (nr[k] - clrCnt[k]) : 0));
      end
   endtask

   // One cycle: check the combinational outputs mid-cycle, then advance the
   // model on the clock edge.
   task automatic tick();
      #3;
      checkAll();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   // Waits until both configurations are ready and returns the cycle count at
   // which each rose. Optionally keeps issuing a write to x3 while C is still
   // clearing.
   task automatic waitReady(input bit wrDuring, output int fa, output int fc);
      int cyc = 0;
      fa = -1;
      fc = -1;
      while (cyc < 100 && !(readyA && readyC)) begin
         RegWrite  = wrDuring && !readyC;
         writeReg  = 5'd3;
         writeData = 64'h77;
         tick();
         cyc++;
         if (readyA && fa < 0) fa = cyc;
         if (readyC && fc < 0) fc = cyc;
      end
      RegWrite = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  wr;
      logic [63:0] wd;
      logic [4:0]  r1, r2, dbg;
      logic [31:0] eA1, eA2, eB1, eDbg;
      logic [63:0] eC1;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int fa, fc;

      vecs[0] = '{1'b1, 5'd5,  64'hCAFEF00D_DEADBEEF, 5'd5,  5'd5, 5'd5,
                  32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0, 64'hCAFEF00D_DEADBEEF};
      vecs[1] = '{1'b0, 5'd0,  64'h0, 5'd5,  5'd5, 5'd5,
                  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 64'hCAFEF00D_DEADBEEF};
      vecs[2] = '{1'b1, 5'd0,  64'h12345678, 5'd0, 5'd0, 5'd0,
                  32'h0, 32'h0, 32'h0, 32'h0, 64'h0};
      vecs[3] = '{1'b0, 5'd0,  64'h0, 5'd0, 5'd0, 5'd0,
                  32'h0, 32'h0, 32'h0, 32'h0, 64'h0};
      vecs[4] = '{1'b1, 5'd1,  64'hA5, 5'd1, 5'd2, 5'd1,
                  32'hA5, 32'h0, 32'h0, 32'h0, 64'hA5};
      vecs[5] = '{1'b0, 5'd0,  64'h0, 5'd1, 5'd1, 5'd1,
                  32'hA5, 32'hA5, 32'hA5, 32'hA5, 64'hA5};
      vecs[6] = '{1'b1, 5'd20, 64'h11, 5'd20, 5'd4, 5'd20,
                  32'h11, 32'h0, 32'h0, 32'h0, 64'h11};
      vecs[7] = '{1'b0, 5'd0,  64'h0, 5'd20, 5'd4, 5'd20,
                  32'h11, 32'h0, 32'h11, 32'h11, 64'h11};

      RegWrite = 1'b0; clr_req = 1'b0; writeReg = '0; writeData = '0;
      readReg1 = '0; readReg2 = '0; dbg_addr = '0;
      modelReset();
      @(posedge clk);
      #1;
      tick();
      tick();
      rst_n = 1'b1;

      // Clear after reset release: 32 (A) and 16 (C) cycles.
      waitReady(1'b0, fa, fc);
      chk("reset clear length A", 64'(fa), 64'd32);
      chk("reset clear length C", 64'(fc), 64'd16);

      for (int i = 0; i < 32; i++) begin
         dbg_addr = 5'(i);
         #2;
         chk("dbg zero after clear A", 64'(dbgA), 64'd0);
         if (i < 16) chk("dbg zero after clear C", dbgC, 64'd0);
         tick();
      end

      // Directed vector table: bypass, x0 writes, address aliasing in C.
      for (int v = 0; v < 8; v++) begin
         RegWrite  = vecs[v].we;
         writeReg  = vecs[v].wr;
         writeData = vecs[v].wd;
         readReg1  = vecs[v].r1;
         readReg2  = vecs[v].r2;
         dbg_addr  = vecs[v].dbg;
         #2;
         chk($sformatf("vec%0d A rd1", v), 64'(rd1A), 64'(vecs[v].eA1));
         chk($sformatf("vec%0d A rd2", v), 64'(rd2A), 64'(vecs[v].eA2));
         chk($sformatf("vec%0d B rd1", v), 64'(rd1B), 64'(vecs[v].eB1));
         chk($sformatf("vec%0d A dbg", v), 64'(dbgA), 64'(vecs[v].eDbg));
         chk($sformatf("vec%0d C rd1", v), rd1C, vecs[v].eC1);
         tick();
      end

      // Clear request with a simultaneous write to x2: the write is dropped.
      RegWrite = 1'b1; writeReg = 5'd2; writeData = 64'h5A; clr_req = 1'b1;
      readReg1 = 5'd2;
      #2;
      chk("no bypass under clr_req", 64'(rd1A), 64'd0);
      tick();
      clr_req = 1'b0;
      RegWrite = 1'b0;
      waitReady(1'b0, fa, fc);
      chk("clr_req clear length A", 64'(fa), 64'd32);
      chk("clr_req clear length C", 64'(fc), 64'd16);
      readReg1 = 5'd1; readReg2 = 5'd2; dbg_addr = 5'd1;
      #2;
      chk("x1 cleared A", 64'(rd1A), 64'd0);
      chk("x2 write dropped A", 64'(rd2A), 64'd0);
      chk("x1 cleared dbg A", 64'(dbgA), 64'd0);
      chk("x1 cleared C", rd1C, 64'd0);
      tick();

      // Reset in the middle of a clear restarts it from zero.
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      repeat (10) tick();
      chk("clr_ptr at cycle 10 A", 64'(ptrA), 64'd10);
      rst_n = 1'b0;
      modelReset();
      #1;
      chk("clr_ptr after mid reset A", 64'(ptrA), 64'd0);
      chk("ready after mid reset A", 64'(readyA), 64'd0);
      chk("ready after mid reset C", 64'(readyC), 64'd0);
      tick();
      rst_n = 1'b1;

      // Writes to x3 during clear are ignored.
      waitReady(1'b1, fa, fc);
      chk("restart clear length A", 64'(fa), 64'd32);
      chk("restart clear length C", 64'(fc), 64'd16);
      readReg1 = 5'd3; readReg2 = 5'd3; dbg_addr = 5'd3;
      #2;
      chk("x3 write during clear A", 64'(rd1A), 64'd0);
      chk("x3 write during clear C", rd1C, 64'd0);
      chk("x3 dbg after clear A", 64'(dbgA), 64'd0);
      tick();

      // Random traffic checked cycle by cycle against the model.
      for (int n = 0; n < 800; n++) begin
         rst_n = 1'b1;
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            modelReset();
         end
         RegWrite  = 1'($urandom);
         writeReg  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         writeData = {$urandom, $urandom};
         readReg1  = ($urandom_range(0, 2) == 0) ? writeReg : 5'($urandom_range(0, 7));
         readReg2  = ($urandom_range(0, 2) == 0) ? writeReg : 5'($urandom);
         dbg_addr  = 5'($urandom_range(0, 7));
         clr_req   = ($urandom_range(0, 59) == 0);
         tick();
      end
      rst_n = 1'b1;
      clr_req = 1'b0;
      RegWrite = 1'b0;

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
